hw_multi_timer: RTL and testbench

- Parametrised multi-channel interval timer on an Avalon-MM slave; successor to the single-channel 16-bit-bus interval timer.
- Adds a 32-bit data bus, NUM_CH independent channels, configurable counter width and a per-channel prescaler.
- Adds a per-channel one-shot or continuous mode, a combined irq and a per-channel timeout pulse vector.
- Sits on the CPU data master; the pulse vector feeds JPEG pipeline stage profiling.

---
 rtl/hw_multi_timer_if.sv | 26 ++
 rtl/hw_multi_timer.sv | 180 ++++++++++++++++++
 tb/tb_hw_multi_timer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hw_multi_timer_if.sv
// Avalon-MM slave bus bundle for hw_multi_timer.
// No waitrequest: a write takes effect on the clock edge where chipselect=1 and write_n=0,
// and readdata shows the register selected by address one cycle later, whether or not chipselect is high.
interface hw_multi_timer_if;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/hw_multi_timer.sv
// Multi-channel interval timer with a per-channel prescaler, one-shot or continuous mode,
// sticky timeout flags, a combined irq and a one-clock timeout pulse per channel.
module hw_multi_timer #(
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 32,
    parameter int PS_W           = 8,
    parameter int DEFAULT_PERIOD = 99
) (
    input  logic               clk,
    input  logic               reset,
    hw_multi_timer_if.slave    bus,
    output logic               irq,
    output logic [NUM_CH-1:0]  timeout_pulse
);

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_SNAP     = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    localparam logic [CNT_W-1:0] DEF_CNT = CNT_W'(DEFAULT_PERIOD);

    logic [CNT_W-1:0] cnt_q      [NUM_CH];
    logic [CNT_W-1:0] cnt_d      [NUM_CH];
    logic [CNT_W-1:0] period_q   [NUM_CH];
    logic [CNT_W-1:0] period_d   [NUM_CH];
    logic [CNT_W-1:0] snap_q     [NUM_CH];
    logic [CNT_W-1:0] snap_d     [NUM_CH];
    logic [PS_W-1:0]  prescale_q [NUM_CH];
    logic [PS_W-1:0]  prescale_d [NUM_CH];
    logic [PS_W-1:0]  ps_cnt_q   [NUM_CH];
    logic [PS_W-1:0]  ps_cnt_d   [NUM_CH];

    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] to_q, to_d;
    logic [NUM_CH-1:0] cont_q, cont_d;
    logic [NUM_CH-1:0] ito_q, ito_d;
    logic [NUM_CH-1:0] reload_q, reload_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [31:0]       readdata_q, readdata_d;

    logic [1:0]        addr_ch;
    logic [2:0]        addr_reg;
    logic              wr_en;
    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] expire;
    logic              unused_wdata;

    assign addr_ch      = bus.address[4:3];
    assign addr_reg     = bus.address[2:0];
    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    // A pending force_reload freezes counting for that cycle so no stale timeout escapes.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i]  = wr_en && (addr_ch == 2'(i));
            tick[i]   = run_q[i] && !reload_q[i] && (ps_cnt_q[i] == '0);
            expire[i] = tick[i] && (cnt_q[i] == '0);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]      = cnt_q[i];
            period_d[i]   = period_q[i];
            snap_d[i]     = snap_q[i];
            prescale_d[i] = prescale_q[i];
            ps_cnt_d[i]   = ps_cnt_q[i];
            run_d[i]      = run_q[i];
            to_d[i]       = to_q[i];
            cont_d[i]     = cont_q[i];
            ito_d[i]      = ito_q[i];
            pulse_d[i]    = expire[i];
            reload_d[i]   = ch_wr[i] && ((addr_reg == REG_PERIOD) || (addr_reg == REG_PRESCALE));

            if (reload_q[i]) begin
                ps_cnt_d[i] = prescale_q[i];
            end else if (run_q[i]) begin
                if (ps_cnt_q[i] == '0) begin
                    ps_cnt_d[i] = prescale_q[i];
                end else begin
                    ps_cnt_d[i] = ps_cnt_q[i] - PS_W'(1);
                end
            end

            if (reload_q[i]) begin
                cnt_d[i] = period_q[i];
            end else if (tick[i]) begin
                cnt_d[i] = expire[i] ? period_q[i] : (cnt_q[i] - CNT_W'(1));
            end

            // Later assignments win: START beats STOP and one-shot expiry, force_reload beats all.
            if (expire[i] && !cont_q[i]) begin
                run_d[i] = 1'b0;
            end
            if (ch_wr[i] && (addr_reg == REG_CONTROL)) begin
                if (bus.writedata[3]) run_d[i] = 1'b0;
                if (bus.writedata[2]) run_d[i] = 1'b1;
                cont_d[i] = bus.writedata[1];
                ito_d[i]  = bus.writedata[0];
            end
            if (reload_q[i]) begin
                run_d[i] = 1'b0;
            end

            if (ch_wr[i] && (addr_reg == REG_STATUS)) begin
                to_d[i] = 1'b0;
            end
            if (expire[i]) begin
                to_d[i] = 1'b1;
            end

            if (ch_wr[i] && (addr_reg == REG_PERIOD)) begin
                period_d[i] = bus.writedata[CNT_W-1:0];
            end
            if (ch_wr[i] && (addr_reg == REG_SNAP)) begin
                snap_d[i] = cnt_q[i];
            end
            if (ch_wr[i] && (addr_reg == REG_PRESCALE)) begin
                prescale_d[i] = bus.writedata[PS_W-1:0];
            end
        end
    end

    always_comb begin
        readdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_ch == 2'(i)) begin
                case (addr_reg)
                    REG_STATUS:   readdata_d = {30'b0, run_q[i], to_q[i]};
                    REG_CONTROL:  readdata_d = {30'b0, cont_q[i], ito_q[i]};
                    REG_PERIOD:   readdata_d[CNT_W-1:0] = period_q[i];
                    REG_SNAP:     readdata_d[CNT_W-1:0] = snap_q[i];
                    REG_PRESCALE: readdata_d[PS_W-1:0]  = prescale_q[i];
                    default:      readdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= DEF_CNT;
                period_q[i]   <= DEF_CNT;
                snap_q[i]     <= '0;
                prescale_q[i] <= '0;
                ps_cnt_q[i]   <= '0;
            end
            run_q      <= '0;
            to_q       <= '0;
            cont_q     <= '0;
            ito_q      <= '0;
            reload_q   <= '0;
            pulse_q    <= '0;
            readdata_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            snap_q     <= snap_d;
            prescale_q <= prescale_d;
            ps_cnt_q   <= ps_cnt_d;
            run_q      <= run_d;
            to_q       <= to_d;
            cont_q     <= cont_d;
            ito_q      <= ito_d;
            reload_q   <= reload_d;
            pulse_q    <= pulse_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata  = readdata_q;
    assign timeout_pulse = pulse_q;
    assign irq           = |(to_q & ito_q);

endmodule

// File: tb/tb_hw_multi_timer.sv
// Bench for hw_multi_timer: directed scenarios plus random bus traffic, checked every cycle
// against a model that tracks each channel as "clocks remaining until the next timeout".
module tb_hw_multi_timer;

    localparam int NCH = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           irq;
    logic [NCH-1:0] timeout_pulse;

    hw_multi_timer_if bus_if ();

    hw_multi_timer #(
        .NUM_CH(NCH), .CNT_W(32), .PS_W(8), .DEFAULT_PERIOD(99)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if),
        .irq(irq),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel model: timeout happens when m_left reaches 0; counter = (m_left-1)/m_q.
    longint         m_left [NCH];
    longint         m_q    [NCH];
    longint         m_per  [NCH];
    longint         m_ps   [NCH];
    logic [31:0]    m_snap [NCH];
    logic [NCH-1:0] m_run, m_to, m_cont, m_ito, m_reload, m_pulse;
    bit             m_irq;
    bit             m_live;
    logic [31:0]    exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_per[i]  = 99;
            m_ps[i]   = 0;
            m_q[i]    = 1;
            m_left[i] = 100;
            m_snap[i] = 0;
        end
        m_run = '0; m_to = '0; m_cont = '0; m_ito = '0; m_reload = '0; m_pulse = '0;
        m_irq  = 0;
        m_live = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic [31:0] rd;
        logic [31:0] wd;
        int          ch;
        int          r;
        bit          wr;
        rd = 0;
        ch = int'(bus_if.address[4:3]);
        r  = int'(bus_if.address[2:0]);
        wr = bus_if.chipselect && !bus_if.write_n;
        wd = bus_if.writedata;
        if (ch < NCH) begin
            case (r)
                0: rd = {30'b0, m_run[ch], m_to[ch]};
                1: rd = {30'b0, m_cont[ch], m_ito[ch]};
                2: rd = 32'(m_per[ch]);
                3: rd = m_snap[ch];
                4: rd = 32'(m_ps[ch]);
                default: rd = 0;
            endcase
        end
        exp_q.push_back(rd);
        for (int i = 0; i < NCH; i++) begin
            bit     hit;
            bit     rl;
            bit     ev;
            longint cnt_pre;
            hit = wr && (ch == i);
            rl  = m_reload[i];
            ev  = 0;
            cnt_pre = (m_left[i] - 1) / m_q[i];
            m_reload[i] = 1'b0;
            if (rl) begin
                m_q[i]    = m_ps[i] + 1;
                m_left[i] = (m_per[i] + 1) * m_q[i];
            end else if (m_run[i]) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    ev        = 1;
                    m_q[i]    = m_ps[i] + 1;
                    m_left[i] = (m_per[i] + 1) * m_q[i];
                end
            end
            if (ev && !m_cont[i]) m_run[i] = 1'b0;
            if (hit && r == 1) begin
                if (wd[3]) m_run[i] = 1'b0;
                if (wd[2]) m_run[i] = 1'b1;
                m_cont[i] = wd[1];
                m_ito[i]  = wd[0];
            end
            if (rl) m_run[i] = 1'b0;
            if (hit && r == 0) m_to[i] = 1'b0;
            if (ev) m_to[i] = 1'b1;
            if (hit && r == 2) begin
                m_per[i]    = longint'(wd);
                m_reload[i] = 1'b1;
            end
            if (hit && r == 3) m_snap[i] = 32'(cnt_pre);
            if (hit && r == 4) begin
                m_ps[i]     = longint'(wd[7:0]);
                m_reload[i] = 1'b1;
            end
            m_pulse[i] = ev;
        end
        m_irq  = |(m_to & m_ito);
        m_live = 1;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    // Scoreboard: readdata, pulses and irq compared on every falling edge.
    always @(negedge clk) begin
        if (!reset && m_live) begin
            if (exp_q.size() > 0) check("readdata", bus_if.readdata, exp_q.pop_front());
            check("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
            check("irq", 32'(irq), 32'(m_irq));
        end
    end

    // Driver tasks: entered and left at a falling edge.
    task automatic bus_write(input int ch, input int r, input logic [31:0] data);
        bus_if.address    = {2'(ch), 3'(r)};
        bus_if.writedata  = data;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input int ch, input int r, output logic [31:0] data);
        bus_if.address    = {2'(ch), 3'(r)};
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        @(negedge clk);
        data = bus_if.readdata;
        bus_if.chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic report();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        report();
        $finish;
    end

    initial begin
        logic [31:0] d;
        logic [31:0] exp_snap;
        int          waited;
        reset             = 1'b1;
        bus_if.address    = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;
        #3;
        check("rst_readdata", bus_if.readdata, 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_pulse", 32'(timeout_pulse), 0);
        idle(2);
        reset = 1'b0;

        bus_read(0, 2, d);
        check("rst_period", d, 99);
        bus_read(0, 0, d);
        check("rst_status", d, 0);

        // ch0 continuous every 10 clocks, ch1 one-shot after 20 clocks
        bus_write(0, 2, 9);
        bus_write(0, 4, 0);
        idle(2);
        bus_write(0, 1, 32'h7);
        bus_write(1, 2, 4);
        bus_write(1, 4, 3);
        idle(2);
        bus_write(1, 1, 32'h4);
        idle(40);
        bus_read(1, 0, d);
        check("oneshot_status", d, 1);
        bus_write(1, 3, 0);
        bus_read(1, 3, d);
        check("oneshot_hold", d, 4);
        bus_write(0, 0, 0);
        idle(12);

        // snapshot while running, then PERIOD write forces a reload and stops
        idle(3);
        exp_snap = 32'((m_left[0] - 1) / m_q[0]);
        bus_write(0, 3, 0);
        bus_read(0, 3, d);
        check("snap_running", d, exp_snap);
        bus_write(0, 2, 50);
        idle(1);
        bus_write(0, 3, 0);
        bus_read(0, 3, d);
        check("reload_count", d, 50);
        bus_read(0, 0, d);
        check("reload_run", 32'(d[1]), 0);

        // STATUS clear in the same cycle as a timeout
        bus_write(0, 2, 5);
        idle(2);
        bus_write(0, 1, 32'h7);
        waited = 0;
        while (!(m_run[0] && m_left[0] == 1) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("coinc_reached", 32'(waited < 100), 1);
        bus_write(0, 0, 0);
        bus_read(0, 0, d);
        check("to_sticky", 32'(d[0]), 1);
        bus_write(0, 1, 32'hC);
        bus_read(0, 0, d);
        check("start_stop_run", 32'(d[1]), 1);

        // absent channels and reserved registers
        bus_write(3, 2, 123);
        bus_read(3, 2, d);
        check("absent_ch", d, 0);
        bus_read(0, 5, d);
        check("reserved_reg", d, 0);
        bus_read(0, 2, d);
        check("absent_no_effect", d, 5);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            int op;
            int ch;
            int r;
            logic [31:0] wd;
            op = $urandom_range(0, 9);
            ch = $urandom_range(0, 3);
            r  = $urandom_range(0, 7);
            if (op < 4) begin
                case (r)
                    1: wd = $urandom_range(0, 15);
                    2: wd = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 15);
                    4: wd = $urandom_range(0, 4);
                    default: wd = $urandom;
                endcase
                bus_write(ch, r, wd);
            end else if (op < 7) begin
                bus_read(ch, r, d);
            end else begin
                idle($urandom_range(1, 6));
            end
        end

        // reset asserted mid-count
        bus_write(0, 2, 3);
        idle(2);
        bus_write(0, 1, 32'h7);
        bus_read(0, 2, d);
        idle(5);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_readdata", bus_if.readdata, 0);
        check("midrst_irq", 32'(irq), 0);
        check("midrst_pulse", 32'(timeout_pulse), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus_read(0, 2, d);
        check("midrst_period", d, 99);
        bus_read(0, 0, d);
        check("midrst_status", d, 0);
        idle(2);

        report();
        $finish;
    end

endmodule
